// File: rtl/unidade_controle_pkg.sv
// unidade_controle_pkg: shared state encodings, db_estado codes and width helper
// for the multiplayer control unit.
//   S_*        : state encodings, also used verbatim as db_estado codes
//   DB_ILEGAL  : db_estado code shown for an unreachable state encoding
//   pw_width() : bit width needed to index n items (never less than 1)
package unidade_controle_pkg;

    localparam logic [4:0] S_INICIAL       = 5'h00;
    localparam logic [4:0] S_INICIALIZA    = 5'h01;
    localparam logic [4:0] S_EXIBE         = 5'h02;
    localparam logic [4:0] S_INICIA_RODADA = 5'h03;
    localparam logic [4:0] S_ESPERA        = 5'h04;
    localparam logic [4:0] S_REGISTRA      = 5'h05;
    localparam logic [4:0] S_COMPARA       = 5'h06;
    localparam logic [4:0] S_PROXIMA       = 5'h07;
    localparam logic [4:0] S_ESPERA_ADIC   = 5'h08;
    localparam logic [4:0] S_REGISTRA_ADIC = 5'h09;
    localparam logic [4:0] S_GRAVA         = 5'h0A;
    localparam logic [4:0] S_AUMENTA       = 5'h0B;
    localparam logic [4:0] S_PASSA_VEZ     = 5'h0C;
    localparam logic [4:0] S_ELIMINA       = 5'h0D;
    localparam logic [4:0] S_FINAL         = 5'h0E;
    localparam logic [4:0] DB_ILEGAL       = 5'h1F;

    function automatic int pw_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/contador_m.sv
// contador_m: modulo-M counter with synchronous clear, enable and end flag.
//   clock, reset : clock and asynchronous active-high reset
//   zera         : clear to 0 (wins over conta)
//   conta        : advance by one, wrapping from M-1 to 0
//   fim          : high while the count equals M-1
module contador_m
    import unidade_controle_pkg::*;
#(
    parameter int M = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int W = pw_width(M);
    localparam logic [W-1:0] ULTIMO = W'(M - 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = zera ? '0 : conta ? ((cnt_q == ULTIMO) ? '0 : cnt_q + 1'b1) : cnt_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign fim = cnt_q == ULTIMO;

endmodule

// File: rtl/unidade_controle_multijogador.sv
// unidade_controle_multijogador: Moore control FSM for an N-player memory game.
// Build option: define UNIDADE_CONTROLE_TIMEOUT_EN to enable the per-move timeout.
//   clock, reset                 : clock, asynchronous active-high reset
//   iniciar, jogada, igual,
//   fimRodada, fimTotal,
//   timeout_en                   : control inputs sampled on the rising edge
//   contaC, zeraC, registraR,
//   zeraR, zeraCL, contaCL,
//   escreve, mostraLeds          : datapath strobes
//   jogador                      : index of the player whose turn it is
//   vivos                        : mask of players still in the game
//   pronto, acertou,
//   errou_timeout                : game over / finished on fimTotal / eliminated by timeout
//   db_estado                    : current state code (0x1F for an illegal encoding)
module unidade_controle_multijogador
    import unidade_controle_pkg::*;
#(
    parameter int N_PLAYERS      = 2,
    parameter int SHOW_CYCLES    = 1000,
    parameter int TIMEOUT_CYCLES = 5000,
    localparam int PW            = pw_width(N_PLAYERS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 iniciar,
    input  logic                 jogada,
    input  logic                 igual,
    input  logic                 fimRodada,
    input  logic                 fimTotal,
    input  logic                 timeout_en,
    output logic                 contaC,
    output logic                 zeraC,
    output logic                 registraR,
    output logic                 zeraR,
    output logic                 zeraCL,
    output logic                 contaCL,
    output logic                 escreve,
    output logic                 mostraLeds,
    output logic [PW-1:0]        jogador,
    output logic [N_PLAYERS-1:0] vivos,
    output logic                 pronto,
    output logic                 acertou,
    output logic                 errou_timeout,
    output logic [4:0]           db_estado
);

    logic [4:0]           state_q, state_d;
    logic [PW-1:0]        jogador_q, jogador_d;
    logic [N_PLAYERS-1:0] vivos_q, vivos_d;
    logic                 acertou_q, acertou_d;
    logic                 entra_adic_q, entra_adic_d;
    logic                 fim_exibe, expira, em_espera, legal, ultimo;
    logic [N_PLAYERS-1:0] vivos_sem_atual;

    // Next alive player after 'atual', searching forward with wrap-around.
    // Iterating from the farthest offset down lets the nearest hit win.
    function automatic logic [PW-1:0] proximo(input logic [PW-1:0] atual,
                                              input logic [N_PLAYERS-1:0] mask);
        logic [PW-1:0]        r;
        logic [N_PLAYERS-1:0] sh;
        int                   idx;
        r = atual;
        for (int i = N_PLAYERS - 1; i >= 1; i--) begin
            idx = (int'(atual) + i) % N_PLAYERS;
            sh  = mask >> idx;
            if (sh[0]) r = PW'(idx);
        end
        return r;
    endfunction

    assign em_espera       = state_q == S_ESPERA || state_q == S_ESPERA_ADIC;
    assign legal           = state_q <= S_FINAL;
    assign vivos_sem_atual = vivos_q & ~(N_PLAYERS'(1) << jogador_q);
    // Exactly one bit left set once the current player is removed.
    assign ultimo          = vivos_sem_atual != '0 &&
                             (vivos_sem_atual & (vivos_sem_atual - 1'b1)) == '0;

    contador_m #(.M(SHOW_CYCLES)) u_exibe (
        .clock (clock),
        .reset (reset),
        .zera  (state_q != S_EXIBE),
        .conta (state_q == S_EXIBE),
        .fim   (fim_exibe)
    );

`ifdef UNIDADE_CONTROLE_TIMEOUT_EN
    logic fim_timeout, errou_q, errou_d;

    contador_m #(.M(TIMEOUT_CYCLES)) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (!em_espera),
        .conta (timeout_en),
        .fim   (fim_timeout)
    );

    assign expira = timeout_en && fim_timeout;

    // A jogada in the expiry cycle wins, so the flag only latches without one.
    always_comb begin
        errou_d = (state_q == S_INICIALIZA) ? 1'b0 :
                  (em_espera && !jogada && expira) ? 1'b1 : errou_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) errou_q <= 1'b0;
        else       errou_q <= errou_d;
    end

    assign errou_timeout = errou_q;
`else
    logic unused_timeout_en;
    assign unused_timeout_en = timeout_en;
    assign expira            = 1'b0;
    assign errou_timeout     = 1'b0;
`endif

    always_comb begin
        state_d = S_INICIAL;
        case (state_q)
            S_INICIAL:       state_d = iniciar ? S_INICIALIZA : S_INICIAL;
            S_INICIALIZA:    state_d = S_EXIBE;
            S_EXIBE:         state_d = fim_exibe ? S_INICIA_RODADA : S_EXIBE;
            S_INICIA_RODADA: state_d = S_ESPERA;
            S_ESPERA:        state_d = jogada ? S_REGISTRA : expira ? S_ELIMINA : S_ESPERA;
            S_REGISTRA:      state_d = S_COMPARA;
            S_COMPARA:       state_d = !igual ? S_ELIMINA : !fimRodada ? S_PROXIMA :
                                       fimTotal ? S_FINAL : S_ESPERA_ADIC;
            S_PROXIMA:       state_d = S_ESPERA;
            S_ESPERA_ADIC:   state_d = jogada ? S_REGISTRA_ADIC : expira ? S_ELIMINA : S_ESPERA_ADIC;
            S_REGISTRA_ADIC: state_d = S_GRAVA;
            S_GRAVA:         state_d = S_AUMENTA;
            S_AUMENTA:       state_d = S_PASSA_VEZ;
            S_PASSA_VEZ:     state_d = S_INICIA_RODADA;
            S_ELIMINA:       state_d = ultimo ? S_FINAL : S_INICIA_RODADA;
            S_FINAL:         state_d = iniciar ? S_INICIALIZA : S_FINAL;
            default:         state_d = S_INICIAL;
        endcase
    end

    // Advancing past the eliminated player with the already-reduced mask means
    // that, when the game ends by elimination, jogador lands on the survivor.
    always_comb begin
        vivos_d      = (state_q == S_INICIALIZA) ? '1 :
                       (state_q == S_ELIMINA) ? vivos_sem_atual : vivos_q;
        jogador_d    = (state_q == S_INICIALIZA) ? '0 :
                       (state_q == S_PASSA_VEZ) ? proximo(jogador_q, vivos_q) :
                       (state_q == S_ELIMINA) ? proximo(jogador_q, vivos_sem_atual) : jogador_q;
        acertou_d    = (state_q == S_INICIALIZA) ? 1'b0 :
                       (state_q == S_COMPARA && igual && fimRodada && fimTotal) ? 1'b1 : acertou_q;
        entra_adic_d = state_d == S_ESPERA_ADIC && state_q != S_ESPERA_ADIC;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= S_INICIAL;
            jogador_q    <= '0;
            vivos_q      <= '1;
            acertou_q    <= 1'b0;
            entra_adic_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            jogador_q    <= jogador_d;
            vivos_q      <= vivos_d;
            acertou_q    <= acertou_d;
            entra_adic_q <= entra_adic_d;
        end
    end

    assign zeraC      = state_q inside {S_INICIAL, S_INICIALIZA, S_INICIA_RODADA};
    // reset is ORed in so the register clear is visible while reset is held.
    assign zeraR      = reset || state_q == S_INICIALIZA;
    assign zeraCL     = state_q == S_INICIALIZA;
    assign contaC     = state_q == S_PROXIMA || entra_adic_q;
    assign registraR  = state_q == S_REGISTRA || state_q == S_REGISTRA_ADIC;
    assign escreve    = state_q == S_GRAVA;
    assign contaCL    = state_q == S_AUMENTA;
    assign mostraLeds = legal && !(state_q inside {S_INICIAL, S_INICIALIZA, S_FINAL});
    assign pronto     = state_q == S_FINAL;
    assign jogador    = jogador_q;
    assign vivos      = vivos_q;
    assign acertou    = acertou_q;
    assign db_estado  = legal ? state_q : DB_ILEGAL;

endmodule

// File: doc/unidade_controle_multijogador.md
UNIDADE_CONTROLE_MULTIJOGADOR -- requirements
Module: unidade_controle_multijogador

Interface
REQ-001 SHALL have parameter N_PLAYERS, default 2, number of players; legal range 2..8.
REQ-002 SHALL have parameter SHOW_CYCLES, default 1000, duration of the initial-move display in clocks; minimum 1.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 5000, clocks allowed per move; minimum 1.
REQ-004 SHALL have ports clock (in, 1, clock) and reset (in, 1, reset, asynchronous, active-high).
REQ-005 SHALL have inputs iniciar, jogada, igual, fimRodada, fimTotal and timeout_en, each 1 bit, all sampled on the rising edge of clock.
REQ-006 SHALL have 1-bit datapath strobe outputs contaC, zeraC, registraR, zeraR, zeraCL, contaCL, escreve and mostraLeds.
REQ-007 SHALL have outputs jogador (out, PW=$clog2(N_PLAYERS), current player), vivos (out, N_PLAYERS, alive mask), pronto, acertou, errou_timeout (out, 1 each) and db_estado (out, 5, state code).

Function
REQ-008 SHALL be a Moore FSM with states INICIAL, INICIALIZA, EXIBE, INICIA_RODADA, ESPERA, REGISTRA, COMPARA, PROXIMA, ESPERA_ADIC, REGISTRA_ADIC, GRAVA, AUMENTA, PASSA_VEZ, ELIMINA and FINAL.
REQ-009 SHALL use these transitions:
- INICIAL: to INICIALIZA on iniciar.
- INICIALIZA: to EXIBE.
- EXIBE: to INICIA_RODADA after exactly SHOW_CYCLES clocks.
- INICIA_RODADA: to ESPERA.
- ESPERA: to REGISTRA on jogada.
- REGISTRA: to COMPARA.
- COMPARA: on !igual to ELIMINA; on igual with !fimRodada to PROXIMA; on igual with fimRodada to FINAL if fimTotal, else to ESPERA_ADIC.
- PROXIMA: to ESPERA.
- ESPERA_ADIC: to REGISTRA_ADIC on jogada.
- REGISTRA_ADIC: to GRAVA.
- GRAVA: to AUMENTA.
- AUMENTA: to PASSA_VEZ.
- PASSA_VEZ: to INICIA_RODADA.
- ELIMINA: to FINAL if one player remains alive, else to INICIA_RODADA.
- FINAL: to INICIALIZA on iniciar.
REQ-010 SHALL, in ESPERA or ESPERA_ADIC, go to ELIMINA with errou_timeout latched high when timeout_en=1 and the timeout counter reaches TIMEOUT_CYCLES-1.
REQ-011 SHALL give priority to jogada when jogada and timeout expiry occur in the same cycle.
REQ-012 SHALL clear the timeout counter in every state other than ESPERA and ESPERA_ADIC; the counter holds while timeout_en=0.
REQ-013 SHALL, in PASSA_VEZ and after ELIMINA, advance jogador to the next alive index modulo N_PLAYERS, wrapping from N_PLAYERS-1 to 0 and skipping eliminated players.
REQ-014 SHALL, in ELIMINA, clear vivos[jogador].
REQ-015 SHALL set vivos to all ones and jogador to 0 in INICIALIZA.
REQ-016 SHALL, in FINAL:
- set acertou=1 when the game ended on fimTotal (jogador is then the finisher);
- otherwise set jogador to the sole surviving player.
REQ-017 SHALL keep jogador, vivos, acertou and errou_timeout stable throughout FINAL until the next INICIALIZA.
REQ-018 SHALL assert the datapath strobes as follows:
- zeraC in INICIAL, INICIALIZA and INICIA_RODADA;
- zeraR and zeraCL in INICIALIZA;
- contaC in PROXIMA and in the cycle entering ESPERA_ADIC;
- registraR in REGISTRA and REGISTRA_ADIC;
- escreve in GRAVA;
- contaCL in AUMENTA;
- mostraLeds in all states except INICIAL, INICIALIZA and FINAL.
REQ-019 SHALL assert pronto only in FINAL.
REQ-020 SHALL drive db_estado with unique codes 0x00..0x0E in the listed state order, and 0x1F for an illegal state.
REQ-021 SHALL recover from any illegal state to INICIAL on the next clock.

Reset
REQ-022 SHALL, on reset, asynchronously force state INICIAL and clear both counters, jogador, acertou and errou_timeout.
REQ-023 SHALL set vivos to all ones on reset.
REQ-024 SHALL hold all strobes at 0 during reset except zeraC and zeraR, which are 1.
REQ-025 SHALL abandon any operation in progress immediately when reset is asserted mid-game.

Configuration
REQ-026 SHALL, with UNIDADE_CONTROLE_TIMEOUT_EN defined, implement the timeout counter and behaviour of REQ-010 to REQ-012.
REQ-027 SHALL, without UNIDADE_CONTROLE_TIMEOUT_EN, omit the counter, ignore timeout_en, never expire, and tie errou_timeout to 0.

Structure
REQ-028 SHALL take state encodings, db_estado codes and the PW width function from shared package unidade_controle_pkg.
REQ-029 SHALL instantiate sub-module contador_m (parametrised modulo counter with clear/enable/end-flag) for the display and timeout counters.

Verification
REQ-030 SHALL cover: N_PLAYERS=3, reset, iniciar; after SHOW_CYCLES clocks db_estado=INICIA_RODADA, jogador=0, vivos=3'b111.
REQ-031 SHALL cover: player 0 correct full sequence plus added move -> contaCL and escreve each pulse once, then jogador=1.
REQ-032 SHALL cover: player 1 gives igual=0 -> vivos=3'b101, then jogador=2; player 2 errs -> FINAL, jogador=0, pronto=1, acertou=0.
REQ-033 SHALL cover: timeout_en=1, no jogada for TIMEOUT_CYCLES clocks -> ELIMINA, errou_timeout=1; jogada on the expiry cycle -> REGISTRA, no elimination.
REQ-034 SHALL cover: jogador=N_PLAYERS-1 with player 0 eliminated -> next jogador=1 (wrap plus skip).
REQ-035 SHALL cover: fimTotal=1 at COMPARA -> FINAL, acertou=1; reset asserted in ESPERA -> INICIAL in the same cycle, vivos all ones.
